// File: rtl/imem_rsp.sv
// rtl/imem_rsp.sv - instruction-memory responder with wait states and loader port
module imem_rsp #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_inst_o,
  output logic [31:0] rsp_addr_o,
  output logic        rsp_err_o,
  input  logic        ld_wen_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        busy_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];
  logic        accept, req_err, rd_en, rd_err, ld_ok;
  logic [31:0] rd_addr;
  logic        unused_ld_bits;

  assign accept  = (state == IDLE) && req_valid_i;
  assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= DEPTH_LIM);
  assign ld_ok   = (ld_addr_i[31:2] < DEPTH_LIM);
  assign unused_ld_bits = ^ld_addr_i[1:0];

  // With no wait states the read happens in the accept cycle, straight off the request.
  assign rd_en   = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == 4'd0));
  assign rd_addr = (WAIT_CYCLES == 0) ? req_addr_i : rsp_addr_o;
  assign rd_err  = (WAIT_CYCLES == 0) ? req_err : rsp_err_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid_i) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE);
    busy_o      = (state != IDLE);
  end

  // Array read sits in the same edge as loader writes: non-blocking update gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 4'd0;
      rsp_valid_o <= 1'b0;
      rsp_inst_o  <= 32'd0;
      rsp_addr_o  <= 32'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= (state_nxt == RESP);
      if (accept) begin
        rsp_addr_o <= req_addr_i;
        rsp_err_o  <= req_err;
        cnt        <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_en) rsp_inst_o <= rd_err ? NOP_INST : mem[rd_addr[AW+1:2]];
    end
  end

  always_ff @(posedge clk) begin
    if (ld_wen_i && ld_ok) mem[ld_addr_i[AW+1:2]] <= ld_wdata_i;
  end

endmodule
